// File: rtl/fu_mult_pipe_pkg.sv
// Shared types for the pipelined multiplier functional unit: datapath widths,
// decoded control, the per-stage record and the branch-mask helpers.
package fu_mult_pipe_pkg;

    typedef logic [63:0] DATA;
    typedef logic [5:0]  PHYS_REG;
    typedef logic [3:0]  B_MASK;
    typedef logic [1:0]  BS_PTR;

    localparam PHYS_REG PHYS_ZERO_REG = 6'h3F;

    typedef struct packed {
        logic [4:0] alu_func;
        logic       rd_mem;
        logic       wr_mem;
        logic       cond_branch;
    } DE_control_t;

    typedef struct packed {
        logic    valid;
        DATA     prod;
        DATA     mcand;
        DATA     mplier;
        PHYS_REG tagDest;
        B_MASK   bmask;
        BS_PTR   bs_ptr;
    } mult_stage_t;

    function automatic logic is_killed(B_MASK m, logic mispredict, B_MASK res_mask);
        return mispredict && ((m & res_mask) != '0);
    endfunction

    function automatic B_MASK clear_bits(B_MASK m, B_MASK bits);
        return m & ~bits;
    endfunction

endpackage

// File: rtl/fu_mult_pipe_stage.sv
// One shift-add step: folds the next BITS multiplier bits into the running
// product, then shifts the multiplicand up and the multiplier down.
module mult_stage
    import fu_mult_pipe_pkg::*;
#(
    parameter int BITS = 16
) (
    input  mult_stage_t stage_in,
    output mult_stage_t stage_out
);

    DATA partial;

    always_comb begin
        partial = '0;
        for (int j = 0; j < BITS; j++) begin
            if (stage_in.mplier[j]) partial = partial + (stage_in.mcand << j);
        end
        stage_out        = stage_in;
        stage_out.prod   = stage_in.prod + partial;
        stage_out.mcand  = stage_in.mcand << BITS;
        stage_out.mplier = stage_in.mplier >> BITS;
    end

endmodule

// File: rtl/fu_mult_pipe.sv
// Pipelined 64x64 multiplier FU returning product[63:0] to the CDB, with a
// bubble-collapsing stall chain and per-stage branch-mask squash/clear.
module fu_mult_pipe
    import fu_mult_pipe_pkg::*;
#(
    parameter int NUM_STAGES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fus_en,
    input  DATA         fus_opA,
    input  DATA         fus_opB,
    input  PHYS_REG     fus_tagDest,
    input  DE_control_t fus_control,
    input  B_MASK       fus_bmask,
    input  BS_PTR       fus_bs_ptr,
    input  logic        br_resolve_en,
    input  B_MASK       br_resolve_mask,
    input  logic        br_mispredict,
    input  logic        cdb_grant,
    output logic        mult_ready,
    output logic        mult_valid,
    output DATA         mult_result,
    output PHYS_REG     mult_tagDest,
    output B_MASK       mult_bmask,
    output BS_PTR       mult_bs_ptr
);

    localparam int BITS = 64 / NUM_STAGES;
    localparam int LAST = NUM_STAGES - 1;

    logic [NUM_STAGES-1:0] vld_q;
    mult_stage_t           stage_q  [NUM_STAGES];
    mult_stage_t           stage_in [NUM_STAGES];
    mult_stage_t           stage_nx [NUM_STAGES];
    logic [NUM_STAGES-1:0] live;
    logic [NUM_STAGES-1:0] free;
    logic                  mispredict;
    B_MASK                 clr_mask;
    logic                  issue_live;
    logic                  sink_unused;

    assign mispredict = br_resolve_en & br_mispredict;
    assign clr_mask   = (br_resolve_en & ~br_mispredict) ? br_resolve_mask : '0;

    // A stage frees when it holds nothing live or its successor frees; a killed
    // stage counts as empty, so squash takes priority over grant and stall.
    always_comb begin
        logic f;
        for (int k = 0; k < NUM_STAGES; k++) begin
            live[k] = vld_q[k] & ~is_killed(stage_q[k].bmask, mispredict, br_resolve_mask);
        end
        free       = '0;
        f          = ~live[LAST] | cdb_grant;
        free[LAST] = f;
        for (int k = LAST - 1; k >= 0; k--) begin
            f       = ~live[k] | f;
            free[k] = f;
        end
    end

    assign issue_live = fus_en & free[0] & ~is_killed(fus_bmask, mispredict, br_resolve_mask);

    always_comb begin
        stage_in[0].valid   = issue_live;
        stage_in[0].prod    = '0;
        stage_in[0].mcand   = fus_opA;
        stage_in[0].mplier  = fus_opB;
        stage_in[0].tagDest = fus_tagDest;
        stage_in[0].bmask   = clear_bits(fus_bmask, clr_mask);
        stage_in[0].bs_ptr  = fus_bs_ptr;
        for (int k = 1; k < NUM_STAGES; k++) begin
            stage_in[k]       = stage_q[k-1];
            stage_in[k].valid = live[k-1];
            stage_in[k].bmask = clear_bits(stage_q[k-1].bmask, clr_mask);
        end
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        mult_stage #(.BITS(BITS)) u_stage (
            .stage_in  (stage_in[g]),
            .stage_out (stage_nx[g])
        );
    end

    // Stage register boundary: valid bits are the only reset state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                vld_q[k] <= free[k] ? stage_nx[k].valid : live[k];
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (free[k]) stage_q[k] <= stage_nx[k];
            else         stage_q[k].bmask <= clear_bits(stage_q[k].bmask, clr_mask);
        end
    end

    assign mult_ready   = free[0];
    assign mult_valid   = live[LAST];
    assign mult_result  = live[LAST] ? stage_q[LAST].prod : '0;
    assign mult_tagDest = live[LAST] ? stage_q[LAST].tagDest : PHYS_ZERO_REG;
    assign mult_bmask   = live[LAST] ? clear_bits(stage_q[LAST].bmask, clr_mask) : '0;
    assign mult_bs_ptr  = live[LAST] ? stage_q[LAST].bs_ptr : '0;

    // Control travels with the op for bookkeeping only; spent shift state is dropped.
    always_comb begin
        sink_unused = ^fus_control ^ ^stage_q[LAST].mcand ^ ^stage_q[LAST].mplier;
        for (int k = 0; k < NUM_STAGES; k++) sink_unused = sink_unused ^ stage_q[k].valid;
    end

    issue_when_ready: assert property (@(posedge clock) disable iff (reset) !(fus_en && !mult_ready));

endmodule

// File: tb/tb_fu_mult_pipe.sv
// Bench for fu_mult_pipe: vector table, directed multi-cycle sequences and a
// randomized run against an in-order queue model of the in-flight ops.
module tb_fu_mult_pipe;
    import fu_mult_pipe_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        fus_en;
    DATA         fus_opA, fus_opB;
    PHYS_REG     fus_tagDest;
    DE_control_t fus_control;
    B_MASK       fus_bmask;
    BS_PTR       fus_bs_ptr;
    logic        br_resolve_en, br_mispredict, cdb_grant;
    B_MASK       br_resolve_mask;
    logic        mult_ready, mult_valid;
    DATA         mult_result;
    PHYS_REG     mult_tagDest;
    B_MASK       mult_bmask;
    BS_PTR       mult_bs_ptr;

    fu_mult_pipe #(.NUM_STAGES(4)) dut (
        .clock(clock), .reset(reset), .fus_en(fus_en), .fus_opA(fus_opA), .fus_opB(fus_opB),
        .fus_tagDest(fus_tagDest), .fus_control(fus_control), .fus_bmask(fus_bmask),
        .fus_bs_ptr(fus_bs_ptr), .br_resolve_en(br_resolve_en), .br_resolve_mask(br_resolve_mask),
        .br_mispredict(br_mispredict), .cdb_grant(cdb_grant), .mult_ready(mult_ready),
        .mult_valid(mult_valid), .mult_result(mult_result), .mult_tagDest(mult_tagDest),
        .mult_bmask(mult_bmask), .mult_bs_ptr(mult_bs_ptr)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    typedef struct {
        DATA     a;
        DATA     b;
        PHYS_REG tag;
        DATA     expv;
    } vec_t;

    typedef struct {
        DATA     prod;
        PHYS_REG tag;
        B_MASK   bmask;
        BS_PTR   bs;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        fus_en          = 1'b0;
        br_resolve_en   = 1'b0;
        br_mispredict   = 1'b0;
        br_resolve_mask = '0;
    endtask

    task automatic issue(input DATA a, input DATA b, input PHYS_REG tag, input B_MASK bm, input BS_PTR bs);
        fus_en      = 1'b1;
        fus_opA     = a;
        fus_opB     = b;
        fus_tagDest = tag;
        fus_bmask   = bm;
        fus_bs_ptr  = bs;
        fus_control = DE_control_t'(8'h5A);
    endtask

    // One cycle of the reference model, evaluated with this cycle's inputs stable.
    task automatic model_cycle();
        exp_t  keep[$];
        B_MASK clr;
        logic  misp;
        clr  = (br_resolve_en && !br_mispredict) ? br_resolve_mask : 4'b0000;
        misp = br_resolve_en && br_mispredict;
        foreach (q[i]) if (!(misp && ((q[i].bmask & br_resolve_mask) != 0))) keep.push_back(q[i]);
        q = keep;
        if (mult_valid) begin
            chk("rnd_has_entry", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                chk("rnd_result", mult_result, q[0].prod);
                chk("rnd_tag", 64'(mult_tagDest), 64'(q[0].tag));
                chk("rnd_bmask", 64'(mult_bmask), 64'(q[0].bmask & ~clr));
                chk("rnd_bs_ptr", 64'(mult_bs_ptr), 64'(q[0].bs));
            end
        end else begin
            chk("rnd_idle_tag", 64'(mult_tagDest), 64'(PHYS_ZERO_REG));
        end
        foreach (q[i]) q[i].bmask = q[i].bmask & ~clr;
        if (mult_valid && cdb_grant && q.size() != 0) void'(q.pop_front());
        if (fus_en && mult_ready && !(misp && ((fus_bmask & br_resolve_mask) != 0)))
            q.push_back('{fus_opA * fus_opB, fus_tagDest, fus_bmask & ~clr, fus_bs_ptr});
    endtask

    initial begin
        vec_t vecs[6];
        vecs[0] = '{64'h10, 64'h30, 6'h10, 64'h300};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'h11, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[2] = '{64'h0, 64'h1234, 6'h12, 64'h0};
        vecs[3] = '{64'h8000_0000_0000_0001, 64'd3, 6'h13, 64'h8000_0000_0000_0003};
        vecs[4] = '{64'h1234_5678, 64'h1_0000_0000, 6'h14, 64'h1234_5678_0000_0000};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'h15, 64'h1};

        reset = 1'b1;
        idle();
        cdb_grant   = 1'b1;
        fus_opA     = '0;
        fus_opB     = '0;
        fus_tagDest = '0;
        fus_bmask   = '0;
        fus_bs_ptr  = '0;
        fus_control = '0;
        #12;
        chk("reset_valid", 64'(mult_valid), 64'd0);
        chk("reset_result", mult_result, 64'd0);
        chk("reset_tag", 64'(mult_tagDest), 64'(PHYS_ZERO_REG));
        chk("reset_bmask", 64'(mult_bmask), 64'd0);
        chk("reset_bs_ptr", 64'(mult_bs_ptr), 64'd0);
        chk("reset_ready", 64'(mult_ready), 64'd1);
        tick();
        reset = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            issue(vecs[v].a, vecs[v].b, vecs[v].tag, 4'b0000, 2'd1);
            tick();
            fus_en = 1'b0;
            repeat (2) tick();
            chk("vec_not_early", 64'(mult_valid), 64'd0);
            tick();
            chk("vec_valid", 64'(mult_valid), 64'd1);
            chk("vec_result", mult_result, vecs[v].expv);
            chk("vec_tag", 64'(mult_tagDest), 64'(vecs[v].tag));
            chk("vec_bs_ptr", 64'(mult_bs_ptr), 64'd1);
            tick();
            chk("vec_after", 64'(mult_valid), 64'd0);
        end

        for (int i = 1; i <= 4; i++) begin
            issue(64'(i * 3), 64'd7, PHYS_REG'(i), 4'b0000, 2'd0);
            tick();
        end
        fus_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk("b2b_valid", 64'(mult_valid), 64'd1);
            chk("b2b_result", mult_result, 64'(i * 21));
            chk("b2b_tag", 64'(mult_tagDest), 64'(i));
            tick();
        end
        chk("b2b_after", 64'(mult_valid), 64'd0);

        cdb_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(64'(100 + i), 64'd5, PHYS_REG'(20 + i), 4'b0000, 2'd2);
            tick();
        end
        fus_en = 1'b0;
        #1;
        chk("stall_ready", 64'(mult_ready), 64'd0);
        chk("stall_valid", 64'(mult_valid), 64'd1);
        chk("stall_result", mult_result, 64'd500);
        tick();
        chk("stall_hold_ready", 64'(mult_ready), 64'd0);
        chk("stall_hold_result", mult_result, 64'd500);
        chk("stall_hold_tag", 64'(mult_tagDest), 64'd20);
        cdb_grant = 1'b1;
        #1;
        chk("stall_grant_ready", 64'(mult_ready), 64'd1);
        tick();
        cdb_grant = 1'b0;
        #1;
        chk("stall_pop_ready", 64'(mult_ready), 64'd1);
        chk("stall_pop_result", mult_result, 64'd505);
        chk("stall_pop_tag", 64'(mult_tagDest), 64'd21);
        cdb_grant = 1'b1;
        tick();
        chk("stall_drain1", mult_result, 64'd510);
        tick();
        chk("stall_drain2", mult_result, 64'd515);
        tick();
        chk("stall_empty", 64'(mult_valid), 64'd0);

        issue(64'd6, 64'd7, 6'd1, 4'b0001, 2'd0);
        tick();
        issue(64'd8, 64'd9, 6'd2, 4'b0010, 2'd3);
        tick();
        idle();
        br_resolve_en = 1'b1; br_mispredict = 1'b1; br_resolve_mask = 4'b0001;
        tick();
        idle();
        tick();
        chk("misp_killed", 64'(mult_valid), 64'd0);
        tick();
        chk("misp_survivor_valid", 64'(mult_valid), 64'd1);
        chk("misp_survivor_result", mult_result, 64'd72);
        chk("misp_survivor_tag", 64'(mult_tagDest), 64'd2);
        chk("misp_survivor_bmask", 64'(mult_bmask), 64'b0010);
        tick();
        chk("misp_after", 64'(mult_valid), 64'd0);

        issue(64'd11, 64'd11, 6'd4, 4'b0100, 2'd0);
        br_resolve_en = 1'b1; br_mispredict = 1'b1; br_resolve_mask = 4'b0100;
        tick();
        idle();
        for (int i = 0; i < 5; i++) begin
            chk("misp_entry_killed", 64'(mult_valid), 64'd0);
            tick();
        end

        issue(64'd3, 64'd5, 6'd3, 4'b0011, 2'd0);
        tick();
        idle();
        tick();
        br_resolve_en = 1'b1; br_mispredict = 1'b0; br_resolve_mask = 4'b0001;
        tick();
        idle();
        tick();
        chk("clr_valid", 64'(mult_valid), 64'd1);
        chk("clr_result", mult_result, 64'd15);
        chk("clr_bmask", 64'(mult_bmask), 64'b0010);
        br_resolve_en = 1'b1; br_mispredict = 1'b0; br_resolve_mask = 4'b0010;
        #1;
        chk("clr_comb_bmask", 64'(mult_bmask), 64'b0000);
        br_mispredict = 1'b1;
        #1;
        chk("kill_out_valid", 64'(mult_valid), 64'd0);
        chk("kill_out_tag", 64'(mult_tagDest), 64'(PHYS_ZERO_REG));
        chk("kill_out_ready", 64'(mult_ready), 64'd1);
        tick();
        idle();
        chk("kill_out_gone", 64'(mult_valid), 64'd0);

        issue(64'd2, 64'd2, 6'd5, 4'b0000, 2'd0);
        tick();
        issue(64'd3, 64'd3, 6'd6, 4'b0000, 2'd0);
        tick();
        idle();
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(mult_valid), 64'd0);
        chk("rst_mid_tag", 64'(mult_tagDest), 64'(PHYS_ZERO_REG));
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rst_no_result", 64'(mult_valid), 64'd0);
        end

        q.delete();
        for (int c = 0; c < 600; c++) begin
            @(posedge clock);
            #1;
            cdb_grant       = ($urandom_range(0, 3) != 0);
            br_resolve_en   = ($urandom_range(0, 9) == 0);
            br_mispredict   = ($urandom_range(0, 2) == 0);
            br_resolve_mask = 4'b0001 << $urandom_range(0, 3);
            #1;
            fus_opA     = {$urandom(), $urandom()};
            fus_opB     = {$urandom(), $urandom()};
            fus_tagDest = PHYS_REG'($urandom_range(0, 62));
            fus_bmask   = B_MASK'($urandom_range(0, 15));
            fus_bs_ptr  = BS_PTR'($urandom_range(0, 3));
            fus_en      = ($urandom_range(0, 2) != 0) && mult_ready;
            @(negedge clock);
            model_cycle();
        end

        @(posedge clock);
        #1;
        idle();
        cdb_grant = 1'b1;
        for (int c = 0; c < 40 && (q.size() != 0 || mult_valid); c++) begin
            @(negedge clock);
            model_cycle();
            @(posedge clock);
            #1;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
        chk("drain_valid", 64'(mult_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fu_mult_pipe.md
Name: fu_mult_pipe

Overview:
- Pipelined 64x64 integer multiplier functional unit.
- Consumes the single issue slot produced by the FU selector: fus_en, opA/opB, tagDest, control, bmask, bs_ptr.
- Returns the low 64 bits of the product toward the CDB under a valid/grant handshake.
- Tracks branch masks per stage: squashes on mispredict, clears mask bits on correct resolution.

Parameters:
- NUM_STAGES, 4, pipeline depth. Must divide 64; each stage consumes 64/NUM_STAGES multiplier bits.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- fus_en  in  1  issue valid from FU selector
- fus_opA  in  DATA  multiplicand
- fus_opB  in  DATA  multiplier
- fus_tagDest  in  PHYS_REG  destination physical tag
- fus_control  in  DE_control_t  decoded control; carried for bookkeeping, not used in arithmetic
- fus_bmask  in  B_MASK  branch dependence mask of the issued op
- fus_bs_ptr  in  BS_PTR  branch stack pointer, carried through
- br_resolve_en  in  1  a branch resolves this cycle
- br_resolve_mask  in  B_MASK  one-hot bit of the resolving branch
- br_mispredict  in  1  resolving branch mispredicted
- cdb_grant  in  1  CDB accepts this cycle's result
- mult_ready  out  1  unit can accept an issue this cycle
- mult_valid  out  1  result available at the last stage
- mult_result  out  DATA  product[63:0]
- mult_tagDest  out  PHYS_REG  tag of the result
- mult_bmask  out  B_MASK  current mask of the result
- mult_bs_ptr  out  BS_PTR  carried branch stack pointer

Behaviour:
- Reset (async, immediate):
  - All stage valid bits clear.
  - mult_valid = 0, mult_result = 0, mult_tagDest = `PHYS_ZERO_REG, mult_bmask = 0, mult_bs_ptr = 0.
  - mult_ready = 1.
- Stage contents: valid, partial product, shifted multiplicand, remaining multiplier bits, tagDest, bmask, bs_ptr.
- Stage k processing: adds the partial products for the next 64/NUM_STAGES multiplier bits (shift-add, mod 2^64). Signedness is irrelevant because only the low 64 bits are kept.
- Latency: issue at cycle t -> mult_valid at cycle t+NUM_STAGES, if no stall occurs.
- Advance rule:
  - Last stage frees when it is empty or cdb_grant=1.
  - Stage k advances when stage k+1 is empty or advancing (bubble-collapsing stall).
  - mult_ready = stage 0 empty or stage 0 advancing.
- Issue handling:
  - fus_en=1 while mult_ready=0: protocol violation; the input is dropped and a simulation assertion fires.
  - fus_en=0: nothing is written into stage 0.
- Output signals:
  - mult_valid = last-stage valid AND NOT (br_resolve_en & br_mispredict & (last.bmask & br_resolve_mask) != 0).
  - When mult_valid=0: mult_result = 0, mult_tagDest = `PHYS_ZERO_REG, mult_bmask = 0.
  - cdb_grant is ignored when mult_valid=0.
- Branch resolution, applied to every stage in the same cycle:
  - Mispredict: any stage whose bmask has the resolving bit set is invalidated; this includes an op entering stage 0 that cycle (its fus_bmask is checked).
  - Correct prediction: the resolving bit is cleared in every stage's bmask and in incoming fus_bmask. mult_bmask shows the cleared bit combinationally in the same cycle.
- Simultaneous events:
  - Kill has priority over advance and grant.
  - A killed last stage frees its slot that cycle, so upstream stages advance.
- Full pipeline with cdb_grant=0: all stages hold, mult_ready=0.
- Empty pipeline: mult_valid=0, mult_ready=1.
- Reset asserted mid-operation: all in-flight ops discarded immediately; no result is emitted after reset deasserts.

Decomposition:
- Shared package (existing sys_defs):
  - DATA, PHYS_REG, B_MASK, BS_PTR, DE_control_t, `PHYS_ZERO_REG.
  - New mult_stage_t struct: valid, prod, mcand, mplier, tagDest, bmask, bs_ptr.
- Sub-module: mult_stage. Combinational partial-product step for one stage, instantiated NUM_STAGES times with a generate loop. fu_mult_pipe owns the registers, stall logic and branch logic.

Test Plan:
- Single op: opA=64'h10, opB=64'h30, tag=6'h10, cdb_grant=1 -> 4 cycles later mult_valid=1, result=64'h300, tagDest=6'h10; the next cycle mult_valid=0.
- Back-to-back: 4 consecutive issues (i*3 x 7, i=1..4) with grant=1 -> valids on 4 consecutive cycles, results 21, 42, 63, 84, in order. Wrap check: opA=64'hFFFF_FFFF_FFFF_FFFF, opB=2 -> result 64'hFFFF_FFFF_FFFF_FFFE.
- Stall: fill 4 ops with cdb_grant=0 -> mult_ready=0 and outputs stable. Raise grant for 1 cycle -> one result pops and mult_ready=1.
- Mispredict: ops with bmask 4'b0001 and 4'b0010 in flight; resolve mask 4'b0001 with mispredict=1 -> the first op never appears, the second completes with the same tag.
- Correct resolve: op with bmask 4'b0011 in flight; resolve 4'b0001, mispredict=0 -> output mult_bmask=4'b0010.
- Reset mid-flight: assert reset with 2 ops in flight -> mult_valid=0 and mult_tagDest=`PHYS_ZERO_REG immediately; no valid appears after deassert.
